apb2axi_cpl_queue: RTL and testbench
====================================

// Module: apb2axi_cpl_queue
// PURPOSE
// - Completion queue directly upstream of the directory's completion port (cq_dir_cpl_*).
// - Collects completion_entry_t records from the read and write response handlers.
// - Arbitrates between the two sources round-robin and buffers records in a FIFO.
// - Delivers records in order, one per cycle, to the directory, which marks the TAG COMPLETE.
// PARAMETERS
// - CQ_DEPTH  8        FIFO entries; power of two, >=2
// - CQ_PTR_W  $clog2(CQ_DEPTH)  pointer width (derived, not overridden)
// PORTS
// - pclk             in   1                          single clock; all logic on posedge
// - preset           in   1                          reset, asynchronous, active-high
// - rd_cq_cpl_vld    in   1                          read handler has a completion
// - rd_cq_cpl_entry  in   $bits(completion_entry_t)  read completion record
// - rd_cq_cpl_rdy    out  1                          read record accepted this cycle
// - wr_cq_cpl_vld    in   1                          write handler has a completion
// - wr_cq_cpl_entry  in   $bits(completion_entry_t)  write completion record
// - wr_cq_cpl_rdy    out  1                          write record accepted this cycle
// - cq_dir_cpl_vld   out  1                          FIFO head valid toward directory
// - cq_dir_cpl_entry out  $bits(completion_entry_t)  FIFO head record
// - cq_dir_cpl_rdy   in   1                          directory accepts head
// - cq_level         out  CQ_PTR_W+1                 current occupancy, 0..CQ_DEPTH
// BEHAVIOUR
// - Reset (preset=1, async):
//   - wr_ptr, rd_ptr, count clear to 0; last_grant=WR.
//   - All outputs go 0 immediately, including both *_rdy and cq_dir_cpl_entry; storage is not cleared.
//   - Reset asserted mid-operation discards all queued records.
// - Storage: mem[CQ_DEPTH], registered writes.
//   - cq_dir_cpl_vld = (count!=0); cq_dir_cpl_entry = mem[rd_ptr] (0 when empty).
// - pop = cq_dir_cpl_vld & cq_dir_cpl_rdy; rd_ptr increments, wrapping modulo CQ_DEPTH.
// - space = (count<CQ_DEPTH) | pop.
//   - A push into a full FIFO is legal in the same cycle as a pop (comb path from cq_dir_cpl_rdy).
// - Arbitration (combinational, at most one grant per cycle):
//   - Only rd valid -> RD; only wr valid -> WR.
//   - Both valid -> the source != last_grant, so RD wins the first tie after reset.
//   - rd_cq_cpl_rdy = space & grant==RD; wr_cq_cpl_rdy = space & grant==WR.
//   - last_grant updates only on an accepted push.
// - push = accepted handshake; mem[wr_ptr] <= granted entry; wr_ptr wraps modulo CQ_DEPTH.
// - count: +1 on push only; -1 on pop only; unchanged on both or neither. cq_level = count.
// - Latency: a record pushed at edge N is visible on cq_dir_cpl_vld after edge N; no bypass when empty.
// - Order: strict FIFO. Throughput: 1 push + 1 pop per cycle sustained.
// - Sources must hold vld/entry stable until rdy; the block does not check this.
// - Assertions: count<=CQ_DEPTH; no push when !space; no pop when empty.
// CONFIGURATION
// - APB2AXI_CQ_STATS_EN defined adds outputs:
//   - cq_cpl_cnt[15:0]: accepted pushes, wraps.
//   - cq_err_cnt[15:0]: pushes with entry.error=1, wraps.
//   - cq_hwm[CQ_PTR_W:0]: maximum count since reset, saturates at CQ_DEPTH.
//   - All three reset to 0 and update on the edge of the event.
// - APB2AXI_CQ_STATS_EN undefined: these ports and counters do not exist; core behaviour is identical.
// TESTING
// - Reset, then a single rd push tag=3 resp=0 -> vld=1 next cycle; entry.tag=3; level=1; pop -> level=0, vld=0.
// - rd and wr valid every cycle, dir_rdy=1 -> grants alternate RD,WR,RD,WR; output tags interleave in order; level<=1.
// - dir_rdy=0, 8 wr pushes tags 0..7 -> level=8, wr_rdy=0 on the 9th.
//   - Raise dir_rdy with rd valid -> push and pop in the same cycle; level stays 8; order 0..7 then the rd tag.
// - Fill and drain 20 records through CQ_DEPTH=8 -> pointer wrap; all 20 tags out in order; no drops or duplicates.
// - Assert preset mid-stream with level=5 -> vld, rd_rdy, wr_rdy, level=0 asynchronously; after release the first push appears alone.
// - With APB2AXI_CQ_STATS_EN: 10 pushes, 3 with error=1, peak level 6 -> cpl_cnt=10, err_cnt=3, hwm=6.

Source files
------------

// File: rtl/apb2axi_cpl_queue_if.sv
// -----------------------------------------------------------------------------
// apb2axi_cpl_pkg / apb2axi_cpl_queue_if
//
// Purpose:
//   completion_entry_t is the record type shared by the read and write
//   response handlers, the completion queue and the directory.
//   The interface groups the completion queue's handshake signals.
//
// Signals (direction as seen by the queue, modport slave):
//   rd_cq_cpl_vld    in   read handler has a completion
//   rd_cq_cpl_entry  in   read completion record
//   rd_cq_cpl_rdy    out  read record accepted this cycle
//   wr_cq_cpl_vld    in   write handler has a completion
//   wr_cq_cpl_entry  in   write completion record
//   wr_cq_cpl_rdy    out  write record accepted this cycle
//   cq_dir_cpl_vld   out  queue head valid toward directory
//   cq_dir_cpl_entry out  queue head record
//   cq_dir_cpl_rdy   in   directory accepts head
//   cq_level         out  current occupancy, 0..CQ_DEPTH
//
// The master modport is the mirror image, used by whoever drives the queue.
// -----------------------------------------------------------------------------
package apb2axi_cpl_pkg;

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] resp;
        logic       error;
    } completion_entry_t;

endpackage

interface apb2axi_cpl_queue_if #(
    parameter int CQ_DEPTH = 8
);
    import apb2axi_cpl_pkg::*;

    localparam int CQ_PTR_W = $clog2(CQ_DEPTH);

    logic              rd_cq_cpl_vld;
    completion_entry_t rd_cq_cpl_entry;
    logic              rd_cq_cpl_rdy;
    logic              wr_cq_cpl_vld;
    completion_entry_t wr_cq_cpl_entry;
    logic              wr_cq_cpl_rdy;
    logic              cq_dir_cpl_vld;
    completion_entry_t cq_dir_cpl_entry;
    logic              cq_dir_cpl_rdy;
    logic [CQ_PTR_W:0] cq_level;

    modport slave (
        input  rd_cq_cpl_vld,
        input  rd_cq_cpl_entry,
        output rd_cq_cpl_rdy,
        input  wr_cq_cpl_vld,
        input  wr_cq_cpl_entry,
        output wr_cq_cpl_rdy,
        output cq_dir_cpl_vld,
        output cq_dir_cpl_entry,
        input  cq_dir_cpl_rdy,
        output cq_level
    );

    modport master (
        output rd_cq_cpl_vld,
        output rd_cq_cpl_entry,
        input  rd_cq_cpl_rdy,
        output wr_cq_cpl_vld,
        output wr_cq_cpl_entry,
        input  wr_cq_cpl_rdy,
        input  cq_dir_cpl_vld,
        input  cq_dir_cpl_entry,
        output cq_dir_cpl_rdy,
        input  cq_level
    );

endinterface

// File: rtl/apb2axi_cpl_queue.sv
// -----------------------------------------------------------------------------
// apb2axi_cpl_queue
//
// Purpose:
//   Completion queue in front of the directory's completion port. Accepts
//   completion records from the read and write response handlers, arbitrates
//   between them round-robin (one grant per cycle), buffers them in a
//   CQ_DEPTH-entry FIFO and presents them in order, one per cycle, to the
//   directory. A push into a full FIFO is allowed in the same cycle as a pop.
//   A pushed record becomes visible on the head one cycle later (no bypass).
//
// Ports:
//   pclk        in   single clock, all logic on posedge
//   preset      in   asynchronous active-high reset; discards queued records
//   cq          slave modport of apb2axi_cpl_queue_if (rd/wr sources,
//               directory head, occupancy)
//
// Optional feature, macro APB2AXI_CQ_STATS_EN:
//   cq_cpl_cnt  out  accepted pushes, 16-bit wrapping
//   cq_err_cnt  out  accepted pushes with entry.error=1, 16-bit wrapping
//   cq_hwm      out  peak occupancy since reset (naturally bounded by CQ_DEPTH)
//   Without the macro these ports and counters do not exist.
// -----------------------------------------------------------------------------

// Occupancy/handshake invariants of the completion queue.
module apb2axi_cpl_queue_chk #(
    parameter int CQ_DEPTH = 8,
    localparam int CQ_PTR_W = $clog2(CQ_DEPTH)
) (
    input logic              pclk,
    input logic              preset,
    input logic [CQ_PTR_W:0] count,
    input logic              space,
    input logic              push,
    input logic              pop
);
    localparam logic [CQ_PTR_W:0] CNT_FULL = (CQ_PTR_W+1)'(CQ_DEPTH);

    a_count_bound: assert property (@(posedge pclk) disable iff (preset)
        count <= CNT_FULL);
    a_push_space: assert property (@(posedge pclk) disable iff (preset)
        push |-> space);
    a_pop_nonempty: assert property (@(posedge pclk) disable iff (preset)
        pop |-> (count != '0));
endmodule

module apb2axi_cpl_queue
    import apb2axi_cpl_pkg::*;
#(
    parameter int CQ_DEPTH = 8,
    localparam int CQ_PTR_W = $clog2(CQ_DEPTH)
) (
    input  logic                 pclk,
    input  logic                 preset,
    apb2axi_cpl_queue_if.slave   cq
`ifdef APB2AXI_CQ_STATS_EN
    ,
    output logic [15:0]          cq_cpl_cnt,
    output logic [15:0]          cq_err_cnt,
    output logic [CQ_PTR_W:0]    cq_hwm
`endif
);

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

    localparam logic [CQ_PTR_W:0]   CNT_FULL = (CQ_PTR_W+1)'(CQ_DEPTH);
    localparam logic [CQ_PTR_W:0]   CNT_ONE  = (CQ_PTR_W+1)'(1);
    localparam logic [CQ_PTR_W-1:0] PTR_ONE  = CQ_PTR_W'(1);

    completion_entry_t   mem_r [CQ_DEPTH];
    logic [CQ_PTR_W-1:0] wr_ptr_r;
    logic [CQ_PTR_W-1:0] rd_ptr_r;
    logic [CQ_PTR_W:0]   count_r;
    logic [CQ_PTR_W:0]   count_nxt_s;
    grant_e              last_grant_r;
    grant_e              grant_s;
    logic                req_s;
    logic                space_s;
    logic                push_s;
    logic                pop_s;
    logic                rd_rdy_s;
    logic                wr_rdy_s;
    logic                head_vld_s;
    completion_entry_t   push_entry_s;

    // Round-robin arbiter: on a tie the source not granted last time wins.
    always_comb begin
        grant_s = GNT_RD;
        req_s   = 1'b0;
        case ({cq.rd_cq_cpl_vld, cq.wr_cq_cpl_vld})
            2'b10: begin
                grant_s = GNT_RD;
                req_s   = 1'b1;
            end
            2'b01: begin
                grant_s = GNT_WR;
                req_s   = 1'b1;
            end
            2'b11: begin
                grant_s = (last_grant_r == GNT_RD) ? GNT_WR : GNT_RD;
                req_s   = 1'b1;
            end
            default: begin
                grant_s = GNT_RD;
                req_s   = 1'b0;
            end
        endcase
    end

    // Handshake decode. The rdy outputs are gated by preset so they read 0
    // for the whole reset window, not just after the next edge.
    always_comb begin
        head_vld_s   = (count_r != '0);
        pop_s        = head_vld_s & cq.cq_dir_cpl_rdy;
        space_s      = (count_r < CNT_FULL) | pop_s;
        rd_rdy_s     = ~preset & space_s & req_s & (grant_s == GNT_RD);
        wr_rdy_s     = ~preset & space_s & req_s & (grant_s == GNT_WR);
        push_s       = rd_rdy_s | wr_rdy_s;
        push_entry_s = (grant_s == GNT_RD) ? cq.rd_cq_cpl_entry : cq.wr_cq_cpl_entry;
    end

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Record storage; deliberately not reset, only the pointers are.
    always_ff @(posedge pclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Pointers, occupancy and arbitration history.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            last_grant_r <= GNT_WR;
        end else begin
            if (push_s) begin
                wr_ptr_r     <= wr_ptr_r + PTR_ONE;
                last_grant_r <= grant_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Head presentation: entry forced to zero while the queue is empty.
    always_comb begin
        cq.cq_dir_cpl_vld   = head_vld_s;
        cq.cq_dir_cpl_entry = head_vld_s ? mem_r[rd_ptr_r] : '0;
        cq.rd_cq_cpl_rdy    = rd_rdy_s;
        cq.wr_cq_cpl_rdy    = wr_rdy_s;
        cq.cq_level         = count_r;
    end

`ifdef APB2AXI_CQ_STATS_EN
    logic [15:0]       cpl_cnt_r;
    logic [15:0]       err_cnt_r;
    logic [CQ_PTR_W:0] hwm_r;

    // Statistics: push/error counters wrap, high-water mark follows count.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cpl_cnt_r <= 16'd0;
            err_cnt_r <= 16'd0;
            hwm_r     <= '0;
        end else begin
            if (push_s) begin
                cpl_cnt_r <= cpl_cnt_r + 16'd1;
            end
            if (push_s && push_entry_s.error) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
            if (count_nxt_s > hwm_r) begin
                hwm_r <= count_nxt_s;
            end
        end
    end

    assign cq_cpl_cnt = cpl_cnt_r;
    assign cq_err_cnt = err_cnt_r;
    assign cq_hwm     = hwm_r;
`endif

    apb2axi_cpl_queue_chk #(
        .CQ_DEPTH (CQ_DEPTH)
    ) u_chk (
        .pclk   (pclk),
        .preset (preset),
        .count  (count_r),
        .space  (space_s),
        .push   (push_s),
        .pop    (pop_s)
    );

endmodule

// File: tb/tb_apb2axi_cpl_queue.sv
module tb_apb2axi_cpl_queue;
    import apb2axi_cpl_pkg::*;

    localparam int CQ_DEPTH = 8;

    logic pclk   = 1'b0;
    logic preset = 1'b1;

    always #5 pclk = ~pclk;

    apb2axi_cpl_queue_if #(.CQ_DEPTH(CQ_DEPTH)) cq_if ();

`ifdef APB2AXI_CQ_STATS_EN
    logic [15:0] cpl_cnt;
    logic [15:0] err_cnt;
    logic [3:0]  hwm;
`endif

    apb2axi_cpl_queue #(.CQ_DEPTH(CQ_DEPTH)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cq         (cq_if)
`ifdef APB2AXI_CQ_STATS_EN
        ,
        .cq_cpl_cnt (cpl_cnt),
        .cq_err_cnt (err_cnt),
        .cq_hwm     (hwm)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic completion_entry_t mk(input logic [7:0] t, input logic e);
        completion_entry_t r;
        r.tag   = t;
        r.resp  = 2'b00;
        r.error = e;
        return r;
    endfunction

    task automatic idle();
        cq_if.rd_cq_cpl_vld   = 1'b0;
        cq_if.rd_cq_cpl_entry = '0;
        cq_if.wr_cq_cpl_vld   = 1'b0;
        cq_if.wr_cq_cpl_entry = '0;
        cq_if.cq_dir_cpl_rdy  = 1'b0;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        idle();
        repeat (2) @(posedge pclk);
        #3;
        preset = 1'b0;
        tick();
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd_tag;
        logic [7:0] wr_tag;
        logic [7:0] last_pushed;
        logic [7:0] sb[$];
        int         pushed;
        int         popped;

        // ---- reset state, with both sources and the directory active ----
        idle();
        cq_if.rd_cq_cpl_vld   = 1'b1;
        cq_if.rd_cq_cpl_entry = mk(8'd3, 1'b0);
        cq_if.wr_cq_cpl_vld   = 1'b1;
        cq_if.cq_dir_cpl_rdy  = 1'b1;
        #2;
        chk("rst_vld",    32'(cq_if.cq_dir_cpl_vld),   32'd0);
        chk("rst_rd_rdy", 32'(cq_if.rd_cq_cpl_rdy),    32'd0);
        chk("rst_wr_rdy", 32'(cq_if.wr_cq_cpl_rdy),    32'd0);
        chk("rst_level",  32'(cq_if.cq_level),         32'd0);
        chk("rst_entry",  32'(cq_if.cq_dir_cpl_entry), 32'd0);

        // ---- single read push tag=3, then pop ----
        do_reset();
        cq_if.rd_cq_cpl_vld   = 1'b1;
        cq_if.rd_cq_cpl_entry = mk(8'd3, 1'b0);
        #1;
        chk("t1_rd_rdy",  32'(cq_if.rd_cq_cpl_rdy),  32'd1);
        chk("t1_no_byp",  32'(cq_if.cq_dir_cpl_vld), 32'd0);
        tick();
        cq_if.rd_cq_cpl_vld = 1'b0;
        #1;
        chk("t1_vld",     32'(cq_if.cq_dir_cpl_vld),       32'd1);
        chk("t1_tag",     32'(cq_if.cq_dir_cpl_entry.tag), 32'd3);
        chk("t1_level",   32'(cq_if.cq_level),             32'd1);
        cq_if.cq_dir_cpl_rdy = 1'b1;
        tick();
        cq_if.cq_dir_cpl_rdy = 1'b0;
        #1;
        chk("t1_level0",  32'(cq_if.cq_level),       32'd0);
        chk("t1_vld0",    32'(cq_if.cq_dir_cpl_vld), 32'd0);

        // ---- both sources every cycle: RD,WR,RD,WR ----
        do_reset();
        rd_tag      = 8'h10;
        wr_tag      = 8'h20;
        last_pushed = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cq_if.rd_cq_cpl_vld   = 1'b1;
            cq_if.rd_cq_cpl_entry = mk(rd_tag, 1'b0);
            cq_if.wr_cq_cpl_vld   = 1'b1;
            cq_if.wr_cq_cpl_entry = mk(wr_tag, 1'b0);
            cq_if.cq_dir_cpl_rdy  = 1'b1;
            #1;
            chk("t2_rd_rdy", 32'(cq_if.rd_cq_cpl_rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_wr_rdy", 32'(cq_if.wr_cq_cpl_rdy), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("t2_level",  32'(cq_if.cq_level),      (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk("t2_out_tag", 32'(cq_if.cq_dir_cpl_entry.tag), 32'(last_pushed));
            end
            if (i % 2 == 0) begin
                last_pushed = rd_tag;
                rd_tag      = rd_tag + 8'd1;
            end else begin
                last_pushed = wr_tag;
                wr_tag      = wr_tag + 8'd1;
            end
            tick();
        end
        cq_if.rd_cq_cpl_vld = 1'b0;
        cq_if.wr_cq_cpl_vld = 1'b0;
        #1;
        chk("t2_last_tag", 32'(cq_if.cq_dir_cpl_entry.tag), 32'h21);
        tick();
        #1;
        chk("t2_level0",   32'(cq_if.cq_level), 32'd0);

        // ---- fill to 8, 9th refused, then push+pop in the same cycle ----
        cq_if.cq_dir_cpl_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cq_if.wr_cq_cpl_vld   = 1'b1;
            cq_if.wr_cq_cpl_entry = mk(8'(i), 1'b0);
            #1;
            chk("t3_fill_rdy", 32'(cq_if.wr_cq_cpl_rdy), 32'd1);
            tick();
        end
        cq_if.wr_cq_cpl_entry = mk(8'd8, 1'b0);
        #1;
        chk("t3_full_lvl",  32'(cq_if.cq_level),             32'd8);
        chk("t3_9th_rdy",   32'(cq_if.wr_cq_cpl_rdy),        32'd0);
        chk("t3_head",      32'(cq_if.cq_dir_cpl_entry.tag), 32'd0);
        cq_if.wr_cq_cpl_vld   = 1'b0;
        cq_if.rd_cq_cpl_vld   = 1'b1;
        cq_if.rd_cq_cpl_entry = mk(8'h40, 1'b0);
        cq_if.cq_dir_cpl_rdy  = 1'b1;
        #1;
        chk("t3_full_push", 32'(cq_if.rd_cq_cpl_rdy), 32'd1);
        tick();
        cq_if.rd_cq_cpl_vld = 1'b0;
        #1;
        chk("t3_lvl_hold",  32'(cq_if.cq_level), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain_vld", 32'(cq_if.cq_dir_cpl_vld), 32'd1);
            chk("t3_drain_tag", 32'(cq_if.cq_dir_cpl_entry.tag), (i < 8) ? 32'(i) : 32'h40);
            tick();
            #1;
        end
        chk("t3_empty_lvl", 32'(cq_if.cq_level),       32'd0);
        chk("t3_empty_vld", 32'(cq_if.cq_dir_cpl_vld), 32'd0);

        // ---- 20 records through the FIFO, pointer wrap, scoreboard ----
        do_reset();
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 300 && popped < 20; c++) begin
            cq_if.wr_cq_cpl_vld   = (pushed < 20);
            cq_if.wr_cq_cpl_entry = mk(8'(100 + pushed), 1'b0);
            cq_if.cq_dir_cpl_rdy  = (c >= 10) && (c % 3 != 2);
            #1;
            chk("t4_level", 32'(cq_if.cq_level), 32'(sb.size()));
            if (cq_if.cq_dir_cpl_vld && cq_if.cq_dir_cpl_rdy) begin
                if (sb.size() == 0) begin
                    chk("t4_spurious_pop", 32'(cq_if.cq_dir_cpl_entry.tag), 32'hFFFF_FFFF);
                end else begin
                    chk("t4_order", 32'(cq_if.cq_dir_cpl_entry.tag), 32'(sb[0]));
                    void'(sb.pop_front());
                end
                popped++;
            end
            if (cq_if.wr_cq_cpl_rdy) begin
                sb.push_back(8'(100 + pushed));
                pushed++;
            end
            tick();
        end
        idle();
        #1;
        chk("t4_pushed", 32'(pushed), 32'd20);
        chk("t4_popped", 32'(popped), 32'd20);
        chk("t4_lvl0",   32'(cq_if.cq_level), 32'd0);

        // ---- asynchronous reset with level=5 ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cq_if.wr_cq_cpl_vld   = 1'b1;
            cq_if.wr_cq_cpl_entry = mk(8'(8'h50 + i), 1'b0);
            tick();
        end
        cq_if.wr_cq_cpl_entry = mk(8'h55, 1'b0);
        cq_if.rd_cq_cpl_vld   = 1'b1;
        cq_if.rd_cq_cpl_entry = mk(8'h66, 1'b0);
        #1;
        chk("t5_lvl5",    32'(cq_if.cq_level),       32'd5);
        chk("t5_vld",     32'(cq_if.cq_dir_cpl_vld), 32'd1);
        #1;
        preset = 1'b1;
        #1;
        chk("t5_ar_vld",    32'(cq_if.cq_dir_cpl_vld),   32'd0);
        chk("t5_ar_rd_rdy", 32'(cq_if.rd_cq_cpl_rdy),    32'd0);
        chk("t5_ar_wr_rdy", 32'(cq_if.wr_cq_cpl_rdy),    32'd0);
        chk("t5_ar_level",  32'(cq_if.cq_level),         32'd0);
        chk("t5_ar_entry",  32'(cq_if.cq_dir_cpl_entry), 32'd0);
        cq_if.wr_cq_cpl_vld   = 1'b0;
        cq_if.rd_cq_cpl_entry = mk(8'h60, 1'b0);
        #2;
        preset = 1'b0;
        #1;
        chk("t5_post_rdy", 32'(cq_if.rd_cq_cpl_rdy),  32'd1);
        chk("t5_post_vld", 32'(cq_if.cq_dir_cpl_vld), 32'd0);
        tick();
        cq_if.rd_cq_cpl_vld = 1'b0;
        #1;
        chk("t5_first_vld", 32'(cq_if.cq_dir_cpl_vld),       32'd1);
        chk("t5_first_tag", 32'(cq_if.cq_dir_cpl_entry.tag), 32'h60);
        chk("t5_first_lvl", 32'(cq_if.cq_level),             32'd1);
        cq_if.cq_dir_cpl_rdy = 1'b1;
        tick();
        cq_if.cq_dir_cpl_rdy = 1'b0;
        #1;
        chk("t5_alone_lvl", 32'(cq_if.cq_level),       32'd0);
        chk("t5_alone_vld", 32'(cq_if.cq_dir_cpl_vld), 32'd0);

`ifdef APB2AXI_CQ_STATS_EN
        // ---- statistics: 10 pushes, 3 errors, peak level 6 ----
        do_reset();
        #1;
        chk("t6_cpl_rst", 32'(cpl_cnt), 32'd0);
        chk("t6_hwm_rst", 32'(hwm),     32'd0);
        for (int i = 0; i < 6; i++) begin
            cq_if.wr_cq_cpl_vld   = 1'b1;
            cq_if.wr_cq_cpl_entry = mk(8'(8'h70 + i), (i % 2 == 1));
            tick();
        end
        #1;
        chk("t6_lvl6", 32'(cq_if.cq_level), 32'd6);
        cq_if.cq_dir_cpl_rdy = 1'b1;
        for (int i = 6; i < 10; i++) begin
            cq_if.wr_cq_cpl_entry = mk(8'(8'h70 + i), 1'b0);
            tick();
        end
        cq_if.wr_cq_cpl_vld = 1'b0;
        repeat (6) tick();
        cq_if.cq_dir_cpl_rdy = 1'b0;
        #1;
        chk("t6_lvl0",    32'(cq_if.cq_level), 32'd0);
        chk("t6_cpl_cnt", 32'(cpl_cnt),        32'd10);
        chk("t6_err_cnt", 32'(err_cnt),        32'd3);
        chk("t6_hwm",     32'(hwm),            32'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
